// File: rtl/apb2_mailbox_pkg.sv
// apb2_mailbox_pkg: register offsets, STATUS/IRQ bit indices and FSM states for the APB2 mailbox slave
package apb2_mailbox_pkg;
  localparam logic [7:0] TXDATA_OFF  = 8'h40;
  localparam logic [7:0] RXDATA_OFF  = 8'h44;
  localparam logic [7:0] STATUS_OFF  = 8'h48;
  localparam logic [7:0] IRQEN_OFF   = 8'h4C;
  localparam logic [7:0] IRQSTAT_OFF = 8'h50;
  localparam int ST_TXFULL  = 0;
  localparam int ST_RXEMPTY = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_UDF     = 3;
  localparam int IRQ_RXNE = 0;
  localparam int IRQ_TXE  = 1;
  localparam int IRQ_OVF  = 2;
  localparam int IRQ_UDF  = 3;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
endpackage

// File: rtl/apb2_mailbox_slave_fifo.sv
// mailbox_sync_fifo: single-clock FIFO with first-word-fall-through head and occupancy count
module mailbox_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/apb2_mailbox_slave.sv
// apb2_mailbox_slave: APB2 slave with byte-strobed control registers, TX/RX mailbox FIFOs and maskable irq
module apb2_mailbox_slave
  import apb2_mailbox_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_WIDTH-1:0]    paddr,
  input  logic [DATA_WIDTH-1:0]    pwdata,
  input  logic [3:0]               pstrb,
  output logic [DATA_WIDTH-1:0]    prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_REGS*32-1:0]   ctrl_o,
  output logic [31:0]              tx_data_o,
  output logic                     tx_valid_o,
  input  logic                     tx_ready_i,
  input  logic [31:0]              rx_data_i,
  input  logic                     rx_valid_i,
  output logic                     rx_ready_o,
  output logic                     irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] st_q;
  logic [3:0] wait_q, irqen_q, irqstat;
  logic ovf_q, udf_q, acc, err, done_wr, done_rd, w1c, unused_ok;
  logic h_ctrl, h_tx, h_rx, h_st, h_en, h_is;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [ADDR_WIDTH-1:0] a;
  logic [ADDR_WIDTH-3:0] idx;
  logic [DATA_WIDTH-1:0] rdata, status, rx_head;
  assign a         = {paddr[ADDR_WIDTH-1:2], 2'b00};
  assign idx       = paddr[ADDR_WIDTH-1:2];
  assign unused_ok = ^paddr[1:0];
  assign h_ctrl    = a < ADDR_WIDTH'(NUM_REGS * 4);
  assign h_tx      = a == ADDR_WIDTH'(TXDATA_OFF);
  assign h_rx      = a == ADDR_WIDTH'(RXDATA_OFF);
  assign h_st      = a == ADDR_WIDTH'(STATUS_OFF);
  assign h_en      = a == ADDR_WIDTH'(IRQEN_OFF);
  assign h_is      = a == ADDR_WIDTH'(IRQSTAT_OFF);
  assign acc       = psel & penable & (st_q == S_SETUP || st_q == S_ACCESS);
  assign pready    = acc & (wait_q == 4'(WAIT_STATES));
  // Full/empty are judged on the pre-cycle FIFO state, so a same-cycle fabric pop/push never rescues the access
  assign err       = pwrite ? ~(h_ctrl | h_tx | h_en | h_is) | (h_tx & tx_full)
                            : ~(h_ctrl | h_rx | h_st | h_en | h_is) | (h_rx & rx_empty);
  assign done_wr   = pready & pwrite & ~err;
  assign done_rd   = pready & ~pwrite & ~err;
  assign w1c       = done_wr & h_is;
  assign pslverr   = pready & err;
  assign prdata    = done_rd ? rdata : '0;
  assign tx_valid_o = ~tx_empty;
  assign rx_ready_o = ~rx_full;
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      st_q   <= S_IDLE;
      wait_q <= '0;
    end else begin
      st_q   <= !psel ? S_IDLE : !penable ? S_SETUP : (acc & ~pready) ? S_ACCESS : S_IDLE;
      wait_q <= (psel & ~penable) ? '0 : (acc & ~pready) ? wait_q + 1'b1 : wait_q;
    end
  end
  always_comb begin
    status = '0;
    status[23:16] = 8'(rx_cnt);
    status[15:8] = 8'(tx_cnt);
    status[ST_UDF] = udf_q;
    status[ST_OVF] = ovf_q;
    status[ST_RXEMPTY] = rx_empty;
    status[ST_TXFULL] = tx_full;
    irqstat = '0;
    irqstat[IRQ_UDF] = udf_q;
    irqstat[IRQ_OVF] = ovf_q;
    irqstat[IRQ_TXE] = tx_empty;
    irqstat[IRQ_RXNE] = ~rx_empty;
  end
  always_comb begin
    rdata = h_rx ? rx_head : h_st ? status : h_en ? {{(DATA_WIDTH-4){1'b0}}, irqen_q}
          : h_is ? {{(DATA_WIDTH-4){1'b0}}, irqstat} : '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (h_ctrl && idx == (ADDR_WIDTH-2)'(i)) rdata = ctrl_o[32*i +: 32];
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      ctrl_o  <= '0;
      irqen_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        for (int b = 0; b < 4; b++)
          if (done_wr && h_ctrl && idx == (ADDR_WIDTH-2)'(i) && pstrb[b])
            ctrl_o[32*i+8*b +: 8] <= pwdata[8*b +: 8];
      if (done_wr & h_en) irqen_q <= pwdata[3:0];
      ovf_q <= (pready & pwrite & h_tx & tx_full) | (ovf_q & ~(w1c & pwdata[IRQ_OVF]));
      udf_q <= (pready & ~pwrite & h_rx & rx_empty) | (udf_q & ~(w1c & pwdata[IRQ_UDF]));
      irq_o <= |(irqen_q & irqstat);
    end
  end
  mailbox_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(pclk), .rst(preset), .push(done_wr & h_tx), .pop(tx_ready_i), .wdata(pwdata),
    .rdata(tx_data_o), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );
  mailbox_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(pclk), .rst(preset), .push(rx_valid_i), .pop(done_rd & h_rx), .wdata(rx_data_i),
    .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );
endmodule

// File: tb/tb_apb2_mailbox_slave.sv
// tb_apb2_mailbox_slave: directed APB/fabric stimulus checked against a queue-based mailbox model
module tb_apb2_mailbox_slave;
  logic pclk = 1'b0;
  logic preset, psel, penable, pwrite, psel3, penable3, tx_ready, rx_valid;
  logic [7:0] paddr;
  logic [31:0] pwdata, prdata, prdata3, tx_data_o, tx_data3, rx_data, rd;
  logic [3:0] pstrb;
  logic pready, pslverr, tx_valid_o, rx_ready_o, irq_o;
  logic pready3, pslverr3, tx_valid3, rx_ready3, irq3;
  logic [127:0] ctrl_o, ctrl3;
  bit er;
  int total = 0, bad = 0;
  logic [31:0] m_ctrl [4];
  logic [31:0] tx_q[$], rx_q[$];
  bit m_ovf, m_udf, m_irq, m_go, m_wr, tpush, tpop, rpush, rpop;
  logic [3:0] m_en, m_st;
  logic [7:0] m_a;
  logic [31:0] m_wd;
  int nt, nr;
  always #5 pclk = ~pclk;
  apb2_mailbox_slave #(.WAIT_STATES(2)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .ctrl_o(ctrl_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .tx_ready_i(tx_ready), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready_o), .irq_o(irq_o)
  );
  apb2_mailbox_slave #(.WAIT_STATES(3)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable3), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3), .ctrl_o(ctrl3), .tx_data_o(tx_data3), .tx_valid_o(tx_valid3),
    .tx_ready_i(1'b0), .rx_data_i(32'h0), .rx_valid_i(1'b0),
    .rx_ready_o(rx_ready3), .irq_o(irq3)
  );
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // expected {pslverr, prdata} for an access, from the model's pre-cycle state
  function automatic logic [32:0] m_resp(input bit wr, input logic [7:0] a);
    if (a < 8'h10) return {1'b0, wr ? 32'h0 : m_ctrl[a[3:2]]};
    case (a)
      8'h40: return wr ? {tx_q.size() == 16, 32'h0} : {1'b1, 32'h0};
      8'h44: return wr ? {1'b1, 32'h0} : (rx_q.size() == 0 ? {1'b1, 32'h0} : {1'b0, rx_q[0]});
      8'h48: return wr ? {1'b1, 32'h0} : {1'b0, 8'h0, 8'(rx_q.size()), 8'(tx_q.size()), 4'h0,
                                           m_udf, m_ovf, rx_q.size() == 0, tx_q.size() == 16};
      8'h4C: return {1'b0, wr ? 32'h0 : {28'h0, m_en}};
      8'h50: return {1'b0, wr ? 32'h0 : {28'h0, m_udf, m_ovf, tx_q.size() == 0, rx_q.size() != 0}};
      default: return {1'b1, 32'h0};
    endcase
  endfunction
  task automatic apb(input bit d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input int ew, input bit pop,
                     output logic [31:0] rdo, output bit ero);
    int w;
    bit ok;
    logic [32:0] e;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    if (d) psel3 = 1'b1; else psel = 1'b1;
    @(negedge pclk);
    if (d) penable3 = 1'b1; else penable = 1'b1;
    w = 0; ok = 0;
    for (int n = 0; n < 32 && !ok; n++) begin
      #1;
      if (d ? pready3 : pready) ok = 1;
      else begin w++; @(negedge pclk); end
    end
    check("pready_timeout", ok, 1);
    rdo = d ? prdata3 : prdata;
    ero = d ? pslverr3 : pslverr;
    check("wait_cycles", w, ew);
    if (!d) begin
      e = m_resp(wr, a);
      check("pslverr", ero, e[32]);
      if (!wr) check("prdata", rdo, e[31:0]);
      m_wr = wr; m_a = a; m_wd = wd; m_st = st; m_go = 1;
    end
    if (pop) tx_ready = 1'b1;
    @(negedge pclk);
    m_go = 0; tx_ready = 1'b0;
    psel = 0; penable = 0; psel3 = 0; penable3 = 0;
  endtask
  task automatic drain(input logic [31:0] base, input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", tx_valid_o, 1);
      check("drain_data", tx_data_o, base + 32'(i));
      @(negedge pclk);
    end
    tx_ready = 1'b0;
    check("drain_empty", tx_valid_o, 0);
  endtask
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_ctrl = '{default: '0};
      tx_q.delete(); rx_q.delete();
      m_ovf = 0; m_udf = 0; m_en = '0; m_irq = 0;
    end else begin
      nt = tx_q.size(); nr = rx_q.size();
      m_irq = |(m_en & {m_udf, m_ovf, nt == 0, nr != 0});
      tpush = m_go && m_wr && m_a == 8'h40 && nt < 16;
      tpop  = tx_ready && nt > 0;
      rpop  = m_go && !m_wr && m_a == 8'h44 && nr > 0;
      rpush = rx_valid && nr < 16;
      if (tpop) void'(tx_q.pop_front());
      if (tpush) tx_q.push_back(m_wd);
      if (rpop) void'(rx_q.pop_front());
      if (rpush) rx_q.push_back(rx_data);
      if (m_go && m_wr && m_a < 8'h10)
        for (int b = 0; b < 4; b++) if (m_st[b]) m_ctrl[m_a[3:2]][8*b +: 8] = m_wd[8*b +: 8];
      if (m_go && m_wr && m_a == 8'h4C) m_en = m_wd[3:0];
      if (m_go && m_wr && m_a == 8'h50) begin
        if (m_wd[2]) m_ovf = 0;
        if (m_wd[3]) m_udf = 0;
      end
      if (m_go && m_wr && m_a == 8'h40 && nt == 16) m_ovf = 1;
      if (m_go && !m_wr && m_a == 8'h44 && nr == 0) m_udf = 1;
    end
  end
  always @(negedge pclk) begin
    check("ctrl_o", ctrl_o, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
    check("tx_valid_o", tx_valid_o, tx_q.size() != 0);
    if (tx_q.size() != 0) check("tx_data_o", tx_data_o, tx_q[0]);
    check("rx_ready_o", rx_ready_o, rx_q.size() < 16);
    check("irq_o", irq_o, m_irq);
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    preset = 0; psel = 0; penable = 0; psel3 = 0; penable3 = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    m_go = 0; m_wr = 0; m_a = 0; m_wd = 0; m_st = 0;
    #1 preset = 1;
    repeat (2) @(negedge pclk);
    check("rst_pready", pready, 0);
    check("rst_pslverr", pslverr, 0);
    check("rst_prdata", prdata, 0);
    check("rst_ctrl", ctrl_o, 0);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_rx_ready", rx_ready_o, 1);
    check("rst_irq", irq_o, 0);
    preset = 0;
    @(negedge pclk);
    // 1: strobed control write with two wait states
    apb(0, 1, 8'h04, 32'hA5A5_5A5A, 4'b0011, 2, 0, rd, er);
    check("t1_ctrl1", ctrl_o[63:32], 32'h0000_5A5A);
    apb(0, 0, 8'h04, 0, 4'h0, 2, 0, rd, er);
    check("t1_readback", rd, 32'h0000_5A5A);
    // 2: fill TX, overflow, then drain in order
    for (int i = 0; i < 16; i++) apb(0, 1, 8'h40, 32'(i), 4'hf, 2, 0, rd, er);
    apb(0, 1, 8'h40, 32'd16, 4'hf, 2, 0, rd, er);
    check("t2_ovf_err", er, 1);
    apb(0, 0, 8'h48, 0, 4'h0, 2, 0, rd, er);
    check("t2_status", rd, 32'h0000_1007);
    drain(32'h0, 16);
    // 3: RX underflow, then fabric push raises irq two cycles later
    apb(0, 0, 8'h44, 0, 4'h0, 2, 0, rd, er);
    check("t3_udf_err", er, 1);
    check("t3_udf_data", rd, 0);
    apb(0, 0, 8'h50, 0, 4'h0, 2, 0, rd, er);
    check("t3_irqstat", rd, 32'hE);
    apb(0, 1, 8'h4C, 32'h1, 4'hf, 2, 0, rd, er);
    rx_valid = 1; rx_data = 32'hDEAD_BEEF;
    @(negedge pclk);
    rx_valid = 0;
    check("t3_irq_c1", irq_o, 0);
    @(negedge pclk);
    check("t3_irq_c2", irq_o, 1);
    apb(0, 0, 8'h44, 0, 4'h0, 2, 0, rd, er);
    check("t3_rx_data", rd, 32'hDEAD_BEEF);
    check("t3_rx_err", er, 0);
    // 4: unmapped read and write to read-only STATUS
    apb(0, 0, 8'h7C, 0, 4'h0, 2, 0, rd, er);
    check("t4_unmap_err", er, 1);
    check("t4_unmap_data", rd, 0);
    apb(0, 0, 8'h48, 0, 4'h0, 2, 0, rd, er);
    check("t4_status_pre", rd, 32'h0000_000E);
    apb(0, 1, 8'h48, 32'hFFFF_FFFF, 4'hf, 2, 0, rd, er);
    check("t4_ro_err", er, 1);
    apb(0, 0, 8'h48, 0, 4'h0, 2, 0, rd, er);
    check("t4_status_post", rd, 32'h0000_000E);
    // 5: simultaneous APB push and fabric pop at count 8, then W1C of sticky flags
    for (int i = 0; i < 8; i++) apb(0, 1, 8'h40, 32'h100 + 32'(i), 4'hf, 2, 0, rd, er);
    apb(0, 1, 8'h40, 32'h108, 4'hf, 2, 1, rd, er);
    apb(0, 0, 8'h48, 0, 4'h0, 2, 0, rd, er);
    check("t5_status_cnt8", rd, 32'h0000_080E);
    drain(32'h101, 8);
    apb(0, 1, 8'h50, 32'hC, 4'hf, 2, 0, rd, er);
    apb(0, 0, 8'h48, 0, 4'h0, 2, 0, rd, er);
    check("t5_status_clr", rd, 32'h0000_0002);
    apb(0, 0, 8'h50, 0, 4'h0, 2, 0, rd, er);
    check("t5_irqstat_clr", rd, 32'h0000_0002);
    // 6: reset during ACCESS on a three-wait-state slave
    apb(1, 1, 8'h00, 32'h1111_1111, 4'hf, 3, 0, rd, er);
    check("t6_pre_ctrl", ctrl3[31:0], 32'h1111_1111);
    pwrite = 1; paddr = 8'h00; pwdata = 32'h2222_2222; pstrb = 4'hf; psel3 = 1;
    @(negedge pclk);
    penable3 = 1;
    @(negedge pclk);
    #1;
    check("t6_in_wait", pready3, 0);
    preset = 1;
    #1;
    check("t6_rst_ctrl", ctrl3, 0);
    check("t6_rst_pready", pready3, 0);
    check("t6_rst_pslverr", pslverr3, 0);
    check("t6_rst_prdata", prdata3, 0);
    check("t6_rst_tx_valid", tx_valid3, 0);
    check("t6_rst_rx_ready", rx_ready3, 1);
    check("t6_rst_irq", irq3, 0);
    check("t6_rst_main_ctrl", ctrl_o, 0);
    @(negedge pclk);
    preset = 0; psel3 = 0; penable3 = 0;
    @(negedge pclk);
    apb(1, 1, 8'h00, 32'h1234_5678, 4'hf, 3, 0, rd, er);
    check("t6_post_err", er, 0);
    check("t6_post_ctrl", ctrl3[31:0], 32'h1234_5678);
    apb(1, 0, 8'h00, 0, 4'h0, 3, 0, rd, er);
    check("t6_post_read", rd, 32'h1234_5678);
    apb(0, 0, 8'h48, 0, 4'h0, 2, 0, rd, er);
    check("t6_main_status", rd, 32'h0000_0002);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
